// File: rtl/wmark_pkg.sv
// Shared constants and FSM state type for the watermark image-buffer arbiter.
package wmark_pkg;
  localparam int unsigned IMG_DIM     = 64;
  localparam int unsigned IMG_SIZE    = IMG_DIM * IMG_DIM;
  localparam int unsigned IMG_ADDR_W  = $clog2(IMG_SIZE);
  localparam int unsigned PIX_W       = 12;
  localparam logic [11:0] CLEAR_COLOR = 12'hDDD;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } wmark_state_e;
endpackage

// File: rtl/wmark_buf_arbiter_if.sv
// Bundle of display, CPU, clear, RAM and statistics signals around the buffer arbiter.
interface wmark_buf_arbiter_if #(
  parameter int unsigned PIX_W  = wmark_pkg::PIX_W,
  parameter int unsigned ADDR_W = wmark_pkg::IMG_ADDR_W
);
  logic              disp_req;
  logic [ADDR_W-1:0] disp_addr;
  logic [PIX_W-1:0]  disp_data;
  logic              disp_valid;
  logic              cpu_req;
  logic [ADDR_W-1:0] cpu_addr;
  logic [PIX_W-1:0]  cpu_wdata;
  logic              cpu_ack;
  logic              clr_start;
  logic              clr_busy;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [PIX_W-1:0]  mem_wdata;
  logic [PIX_W-1:0]  mem_rdata;
  logic [15:0]       stall_cnt;

  modport slave (
    input  disp_req, disp_addr, cpu_req, cpu_addr, cpu_wdata, clr_start, mem_rdata,
    output disp_data, disp_valid, cpu_ack, clr_busy, mem_en, mem_we, mem_addr, mem_wdata,
    output stall_cnt
  );

  modport master (
    output disp_req, disp_addr, cpu_req, cpu_addr, cpu_wdata, clr_start, mem_rdata,
    input  disp_data, disp_valid, cpu_ack, clr_busy, mem_en, mem_we, mem_addr, mem_wdata,
    input  stall_cnt
  );
endinterface

// File: rtl/wmark_clear_seq.sv
// Clear address counter; wraps to 0 after the last pixel and flags that final write.
module wmark_clear_seq #(
  parameter int unsigned ADDR_W = wmark_pkg::IMG_ADDR_W,
  parameter int unsigned DEPTH  = wmark_pkg::IMG_SIZE
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic              i_advance,
  output logic [ADDR_W-1:0] o_addr,
  output logic              o_done
);
  logic [ADDR_W-1:0] r_addr;

  assign o_addr = r_addr;
  assign o_done = (r_addr == ADDR_W'(DEPTH - 1));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_addr <= '0;
    end else if (i_start) begin
      r_addr <= '0;
    end else if (i_advance) begin
      r_addr <= o_done ? '0 : r_addr + 1'b1;
    end
  end
endmodule

// File: rtl/wmark_buf_arbiter.sv
// Single-port image buffer arbiter: display read > clear write > CPU write.
// Optional CPU stall counter enabled by defining WMARK_BUF_STATS_EN.
module wmark_buf_arbiter #(
  parameter int unsigned      PIX_W       = wmark_pkg::PIX_W,
  parameter int unsigned      ADDR_W      = 12,
  parameter logic [PIX_W-1:0] CLEAR_COLOR = PIX_W'(wmark_pkg::CLEAR_COLOR)
) (
  input  logic               CLK,
  input  logic               RST_N,
  wmark_buf_arbiter_if.slave bus
);
  import wmark_pkg::*;

  wmark_state_e      r_state, w_next;
  logic              w_disp_gnt, w_clr_gnt, w_cpu_gnt, w_clr_start, w_clr_done;
  logic [ADDR_W-1:0] w_clr_addr;
  logic              r_rd_pend, r_disp_valid, r_cpu_ack;
  logic [PIX_W-1:0]  r_disp_data;

  wmark_clear_seq #(
    .ADDR_W (ADDR_W),
    .DEPTH  (IMG_SIZE)
  ) u_clear_seq (
    .i_clk     (CLK),
    .i_rst_n   (RST_N),
    .i_start   (w_clr_start),
    .i_advance (w_clr_gnt),
    .o_addr    (w_clr_addr),
    .o_done    (w_clr_done)
  );

  // Grants are forced off while RST_N is low so the RAM port stays quiet in reset.
  always_comb begin
    w_next      = r_state;
    w_disp_gnt  = 1'b0;
    w_clr_gnt   = 1'b0;
    w_cpu_gnt   = 1'b0;
    w_clr_start = 1'b0;
    if (RST_N) begin
      w_disp_gnt = bus.disp_req;
      case (r_state)
        ST_IDLE: begin
          if (bus.clr_start) begin
            w_next      = ST_CLEAR;
            w_clr_start = 1'b1;
          end else begin
            w_cpu_gnt = bus.cpu_req && !bus.disp_req && !r_cpu_ack;
          end
        end
        ST_CLEAR: begin
          w_clr_gnt = !bus.disp_req;
          if (w_clr_gnt && w_clr_done) w_next = ST_IDLE;
        end
        default: w_next = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    bus.mem_en    = w_disp_gnt | w_clr_gnt | w_cpu_gnt;
    bus.mem_we    = w_clr_gnt | w_cpu_gnt;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    if (w_disp_gnt) begin
      bus.mem_addr = bus.disp_addr;
    end else if (w_clr_gnt) begin
      bus.mem_addr  = w_clr_addr;
      bus.mem_wdata = CLEAR_COLOR;
    end else if (w_cpu_gnt) begin
      bus.mem_addr  = bus.cpu_addr;
      bus.mem_wdata = bus.cpu_wdata;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state      <= ST_IDLE;
      r_rd_pend    <= 1'b0;
      r_disp_valid <= 1'b0;
      r_disp_data  <= '0;
      r_cpu_ack    <= 1'b0;
    end else begin
      r_state      <= w_next;
      r_rd_pend    <= w_disp_gnt;
      r_disp_valid <= r_rd_pend;
      if (r_rd_pend) r_disp_data <= bus.mem_rdata;
      r_cpu_ack    <= w_cpu_gnt;
    end
  end

  assign bus.disp_data  = r_disp_data;
  assign bus.disp_valid = r_disp_valid;
  assign bus.cpu_ack    = r_cpu_ack;
  assign bus.clr_busy   = (r_state == ST_CLEAR);

`ifdef WMARK_BUF_STATS_EN
  logic [15:0] r_stall_cnt;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_stall_cnt <= '0;
    end else if (bus.cpu_req && !w_cpu_gnt && !r_cpu_ack && (r_stall_cnt != '1)) begin
      r_stall_cnt <= r_stall_cnt + 16'd1;
    end
  end

  assign bus.stall_cnt = r_stall_cnt;
`else
  assign bus.stall_cnt = '0;
`endif
endmodule
